// File: rtl/decode_stage.sv
// decode_stage: registered RV32I(+M) decode stage between fetch and execute.
// The decoded beat is held in an output register backed by one skid register,
// so the stage sustains one beat per cycle and absorbs a single cycle of
// backpressure without dropping the beat already in flight.
//
// Ports
//   clk, rst         clock, synchronous active-high reset
//   flush            squash everything held plus the beat offered this cycle
//   in_valid/ready   fetch-side handshake; in_ready is low only when the skid is full
//   in_insn, in_pc   instruction word and its pc
//   out_valid/ready  execute-side handshake
//   out_*            decoded payload: pc, immediate, register indices, ALU code,
//                    operand selects, reg write, load/store kind, M-op, illegal
module decode_stage #(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned ENABLE_M  = 0,
    parameter int unsigned CHECK_ILL = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_insn,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_imm,
    output logic [4:0]      out_rd,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [4:0]      out_alu_code,
    output logic            out_alu_op1_sel,
    output logic            out_alu_op2_sel,
    output logic            out_reg_we,
    output logic [2:0]      out_is_load,
    output logic [1:0]      out_is_store,
    output logic            out_is_md,
    output logic [2:0]      out_md_op,
    output logic            out_illegal
);
    localparam logic [4:0] ALU_ADD = 5'd0, ALU_SUB = 5'd1, ALU_SLL = 5'd2, ALU_SLT = 5'd3;
    localparam logic [4:0] ALU_SLTU = 5'd4, ALU_XOR = 5'd5, ALU_SRL = 5'd6, ALU_SRA = 5'd7;
    localparam logic [4:0] ALU_OR = 5'd8, ALU_AND = 5'd9, ALU_BEQ = 5'd10, ALU_BNE = 5'd11;
    localparam logic [4:0] ALU_BLT = 5'd12, ALU_BGE = 5'd13, ALU_BLTU = 5'd14, ALU_BGEU = 5'd15;
    localparam logic [4:0] ALU_PASS2 = 5'd16, ALU_JAL = 5'd17, ALU_JALR = 5'd18;
    localparam logic ALU_OP1_RS1 = 1'b0, ALU_OP1_PC = 1'b1;
    localparam logic ALU_OP2_RS2 = 1'b0, ALU_OP2_IMM = 1'b1;
    localparam logic [2:0] LOAD_DISABLE = 3'd0, LOAD_LB = 3'd1, LOAD_LH = 3'd2, LOAD_LW = 3'd3;
    localparam logic [2:0] LOAD_LBU = 3'd4, LOAD_LHU = 3'd5;
    localparam logic [1:0] STORE_DISABLE = 2'd0, STORE_SB = 2'd1, STORE_SH = 2'd2;
    localparam logic [1:0] STORE_SW = 2'd3;

    localparam logic [6:0] OP_REG = 7'b0110011, OP_IMM = 7'b0010011, OP_LUI = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111, OP_LOAD = 7'b0000011, OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011, OP_JAL = 7'b1101111, OP_JALR = 7'b1100111;

    // Occupancy: StOne = output register full, StTwo = skid register full as well.
    localparam logic [1:0] StEmpty = 2'd0, StOne = 2'd1, StTwo = 2'd2;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] imm;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      alu_code;
        logic            op1_sel;
        logic            op2_sel;
        logic            reg_we;
        logic [2:0]      is_load;
        logic [1:0]      is_store;
        logic            is_md;
        logic [2:0]      md_op;
        logic            illegal;
    } dec_t;

    dec_t       dec, out_q, out_d, skid_q, skid_d;
    logic [1:0] state_q, state_d;
    logic [6:0] opcode, funct7;
    logic [2:0] funct3;
    logic [31:0] imm32;
    logic       ill, we, accept;

    assign opcode = in_insn[6:0];
    assign funct3 = in_insn[14:12];
    assign funct7 = in_insn[31:25];

    always_comb begin
        dec          = '0;
        dec.pc       = in_pc;
        dec.rd       = in_insn[11:7];
        dec.rs1      = in_insn[19:15];
        dec.rs2      = in_insn[24:20];
        dec.alu_code = ALU_ADD;
        dec.op1_sel  = ALU_OP1_RS1;
        dec.op2_sel  = ALU_OP2_RS2;
        imm32        = '0;
        ill          = 1'b0;
        we           = 1'b0;
        case (opcode)
            OP_REG: begin
                we = 1'b1;
                if (ENABLE_M != 0 && funct7 == 7'b0000001) begin
                    dec.is_md = 1'b1;
                    dec.md_op = funct3;
                end else begin
                    case (funct3)
                        3'd0:    dec.alu_code = funct7[5] ? ALU_SUB : ALU_ADD;
                        3'd1:    dec.alu_code = ALU_SLL;
                        3'd2:    dec.alu_code = ALU_SLT;
                        3'd3:    dec.alu_code = ALU_SLTU;
                        3'd4:    dec.alu_code = ALU_XOR;
                        3'd5:    dec.alu_code = funct7[5] ? ALU_SRA : ALU_SRL;
                        3'd6:    dec.alu_code = ALU_OR;
                        default: dec.alu_code = ALU_AND;
                    endcase
                    // 0100000 only selects SUB/SRA; any other funct7 is unknown.
                    ill = !(funct7 == 7'b0000000 ||
                            (funct7 == 7'b0100000 && (funct3 == 3'd0 || funct3 == 3'd5)));
                end
            end
            OP_IMM: begin
                we          = 1'b1;
                dec.op2_sel = ALU_OP2_IMM;
                imm32       = {{20{in_insn[31]}}, in_insn[31:20]};
                case (funct3)
                    3'd0:    dec.alu_code = ALU_ADD;
                    3'd1: begin
                        dec.alu_code = ALU_SLL;
                        ill          = (funct7 != 7'b0000000);
                    end
                    3'd2:    dec.alu_code = ALU_SLT;
                    3'd3:    dec.alu_code = ALU_SLTU;
                    3'd4:    dec.alu_code = ALU_XOR;
                    3'd5: begin
                        dec.alu_code = funct7[5] ? ALU_SRA : ALU_SRL;
                        ill          = !(funct7 == 7'b0000000 || funct7 == 7'b0100000);
                    end
                    3'd6:    dec.alu_code = ALU_OR;
                    default: dec.alu_code = ALU_AND;
                endcase
            end
            OP_LUI: begin
                we           = 1'b1;
                dec.op2_sel  = ALU_OP2_IMM;
                dec.alu_code = ALU_PASS2;
                imm32        = {in_insn[31:12], 12'b0};
            end
            OP_AUIPC: begin
                we          = 1'b1;
                dec.op1_sel = ALU_OP1_PC;
                dec.op2_sel = ALU_OP2_IMM;
                imm32       = {in_insn[31:12], 12'b0};
            end
            OP_LOAD: begin
                we          = 1'b1;
                dec.op2_sel = ALU_OP2_IMM;
                imm32       = {{20{in_insn[31]}}, in_insn[31:20]};
                case (funct3)
                    3'd0:    dec.is_load = LOAD_LB;
                    3'd1:    dec.is_load = LOAD_LH;
                    3'd2:    dec.is_load = LOAD_LW;
                    3'd4:    dec.is_load = LOAD_LBU;
                    3'd5:    dec.is_load = LOAD_LHU;
                    default: ill = 1'b1;
                endcase
            end
            OP_STORE: begin
                dec.op2_sel = ALU_OP2_IMM;
                imm32       = {{20{in_insn[31]}}, in_insn[31:25], in_insn[11:7]};
                case (funct3)
                    3'd0:    dec.is_store = STORE_SB;
                    3'd1:    dec.is_store = STORE_SH;
                    3'd2:    dec.is_store = STORE_SW;
                    default: ill = 1'b1;
                endcase
            end
            OP_BRANCH: begin
                imm32 = {{19{in_insn[31]}}, in_insn[31], in_insn[7], in_insn[30:25],
                         in_insn[11:8], 1'b0};
                case (funct3)
                    3'd0:    dec.alu_code = ALU_BEQ;
                    3'd1:    dec.alu_code = ALU_BNE;
                    3'd4:    dec.alu_code = ALU_BLT;
                    3'd5:    dec.alu_code = ALU_BGE;
                    3'd6:    dec.alu_code = ALU_BLTU;
                    3'd7:    dec.alu_code = ALU_BGEU;
                    default: ill = 1'b1;
                endcase
            end
            OP_JAL: begin
                we           = 1'b1;
                dec.op1_sel  = ALU_OP1_PC;
                dec.op2_sel  = ALU_OP2_IMM;
                dec.alu_code = ALU_JAL;
                imm32 = {{11{in_insn[31]}}, in_insn[31], in_insn[19:12], in_insn[20],
                         in_insn[30:21], 1'b0};
            end
            OP_JALR: begin
                we           = 1'b1;
                dec.op2_sel  = ALU_OP2_IMM;
                dec.alu_code = ALU_JALR;
                imm32        = {{20{in_insn[31]}}, in_insn[31:20]};
                ill          = (funct3 != 3'd0);
            end
            default: ill = 1'b1;
        endcase

        dec.imm     = XLEN'($signed(imm32));
        dec.illegal = (CHECK_ILL != 0) && ill;
        // Illegal beats still travel to execute, but must have no side effects.
        if (dec.illegal) begin
            dec.alu_code = ALU_ADD;
            dec.op1_sel  = ALU_OP1_RS1;
            dec.op2_sel  = ALU_OP2_RS2;
            dec.is_load  = LOAD_DISABLE;
            dec.is_store = STORE_DISABLE;
            dec.is_md    = 1'b0;
            dec.md_op    = 3'd0;
        end
        dec.reg_we = we && (dec.rd != 5'd0) && !dec.illegal;
    end

    assign in_ready  = (state_q != StTwo);
    assign out_valid = (state_q != StEmpty);
    assign accept    = in_valid && in_ready;

    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = StEmpty;
        end else begin
            case (state_q)
                StEmpty: begin
                    if (accept) begin
                        out_d   = dec;
                        state_d = StOne;
                    end
                end
                StOne: begin
                    if (accept && out_ready) begin
                        out_d = dec;
                    end else if (accept) begin
                        skid_d  = dec;
                        state_d = StTwo;
                    end else if (out_ready) begin
                        state_d = StEmpty;
                    end
                end
                StTwo: begin
                    if (out_ready) begin
                        out_d   = skid_q;
                        state_d = StOne;
                    end
                end
                default: state_d = StEmpty;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StEmpty;
            out_q   <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            skid_q  <= skid_d;
        end
    end

    assign out_pc          = out_q.pc;
    assign out_imm         = out_q.imm;
    assign out_rd          = out_q.rd;
    assign out_rs1         = out_q.rs1;
    assign out_rs2         = out_q.rs2;
    assign out_alu_code    = out_q.alu_code;
    assign out_alu_op1_sel = out_q.op1_sel;
    assign out_alu_op2_sel = out_q.op2_sel;
    assign out_reg_we      = out_q.reg_we;
    assign out_is_load     = out_q.is_load;
    assign out_is_store    = out_q.is_store;
    assign out_is_md       = out_q.is_md;
    assign out_md_op       = out_q.md_op;
    assign out_illegal     = out_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: two instances (M extension on / off) share one stimulus
// stream. A reference queue of held beats plus a rule-based decoder predicts
// every handshake and payload value.
module tb_decode_stage;
    localparam logic [4:0] ALU_ADD = 5'd0, ALU_SUB = 5'd1, ALU_SLL = 5'd2, ALU_SLT = 5'd3;
    localparam logic [4:0] ALU_SLTU = 5'd4, ALU_XOR = 5'd5, ALU_SRL = 5'd6, ALU_SRA = 5'd7;
    localparam logic [4:0] ALU_OR = 5'd8, ALU_AND = 5'd9, ALU_BEQ = 5'd10, ALU_BNE = 5'd11;
    localparam logic [4:0] ALU_BLT = 5'd12, ALU_BGE = 5'd13, ALU_BLTU = 5'd14, ALU_BGEU = 5'd15;
    localparam logic [4:0] ALU_PASS2 = 5'd16, ALU_JAL = 5'd17, ALU_JALR = 5'd18;

    logic clk = 1'b0;
    logic rst, flush, in_valid, out_ready;
    logic [31:0] in_insn, in_pc;
    always #5 clk = ~clk;

    logic m_in_ready, m_out_valid, n_in_ready, n_out_valid;
    logic [31:0] m_pc, m_imm, n_pc, n_imm;
    logic [4:0] m_rd, m_rs1, m_rs2, m_alu, n_rd, n_rs1, n_rs2, n_alu;
    logic m_o1, m_o2, m_we, m_md, m_ill, n_o1, n_o2, n_we, n_md, n_ill;
    logic [2:0] m_ld, m_mdop, n_ld, n_mdop;
    logic [1:0] m_st, n_st;

    decode_stage #(.XLEN(32), .ENABLE_M(1), .CHECK_ILL(1)) dut_m (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(m_in_ready),
        .in_insn(in_insn), .in_pc(in_pc), .out_valid(m_out_valid), .out_ready(out_ready),
        .out_pc(m_pc), .out_imm(m_imm), .out_rd(m_rd), .out_rs1(m_rs1), .out_rs2(m_rs2),
        .out_alu_code(m_alu), .out_alu_op1_sel(m_o1), .out_alu_op2_sel(m_o2),
        .out_reg_we(m_we), .out_is_load(m_ld), .out_is_store(m_st), .out_is_md(m_md),
        .out_md_op(m_mdop), .out_illegal(m_ill)
    );

    decode_stage #(.XLEN(32), .ENABLE_M(0), .CHECK_ILL(1)) dut_n (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(n_in_ready),
        .in_insn(in_insn), .in_pc(in_pc), .out_valid(n_out_valid), .out_ready(out_ready),
        .out_pc(n_pc), .out_imm(n_imm), .out_rd(n_rd), .out_rs1(n_rs1), .out_rs2(n_rs2),
        .out_alu_code(n_alu), .out_alu_op1_sel(n_o1), .out_alu_op2_sel(n_o2),
        .out_reg_we(n_we), .out_is_load(n_ld), .out_is_store(n_st), .out_is_md(n_md),
        .out_md_op(n_mdop), .out_illegal(n_ill)
    );

    logic [96:0] obs_m, obs_n;
    assign obs_m = {m_pc, m_imm, m_rd, m_rs1, m_rs2, m_alu, m_o1, m_o2, m_we, m_ld, m_st,
                    m_md, m_mdop, m_ill};
    assign obs_n = {n_pc, n_imm, n_rd, n_rs1, n_rs2, n_alu, n_o1, n_o2, n_we, n_ld, n_st,
                    n_md, n_mdop, n_ill};

    typedef struct {
        logic [31:0] insn;
        logic [31:0] pc;
    } beat_t;
    beat_t q[$];

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string tag, input logic [96:0] obs, input logic [96:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Reference decoder built straight from the RV32I/M field rules.
    function automatic logic [96:0] ref_dec(input logic [31:0] insn, input logic [31:0] pc,
                                            input bit em);
        logic [6:0] op, f7;
        logic [2:0] f3, ld, mdop;
        logic [1:0] st;
        logic [31:0] imm;
        logic [4:0] alu;
        logic o1, o2, we, md, ill;
        int sx;
        logic [4:0] rr_tab [8];
        logic [4:0] br_tab [8];
        logic [2:0] ld_tab [8];
        rr_tab = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
        br_tab = '{ALU_BEQ, ALU_BNE, ALU_ADD, ALU_ADD, ALU_BLT, ALU_BGE, ALU_BLTU, ALU_BGEU};
        ld_tab = '{3'd1, 3'd2, 3'd3, 3'd0, 3'd4, 3'd5, 3'd0, 3'd0};
        op = insn[6:0]; f3 = insn[14:12]; f7 = insn[31:25]; sx = $signed(insn);
        imm = 0; alu = ALU_ADD; o1 = 0; o2 = 0; we = 0; md = 0; ill = 0;
        ld = 0; st = 0; mdop = 0;
        case (op)
            7'b0110011: begin
                we = 1;
                if (em && f7 == 7'h01) begin md = 1; mdop = f3; end
                else if (f7 == 7'h00) alu = rr_tab[f3];
                else if (f7 == 7'h20 && f3 == 3'd0) alu = ALU_SUB;
                else if (f7 == 7'h20 && f3 == 3'd5) alu = ALU_SRA;
                else ill = 1;
            end
            7'b0010011: begin
                we = 1; o2 = 1; imm = sx >>> 20; alu = rr_tab[f3];
                if (f3 == 3'd1 && f7 != 7'h00) ill = 1;
                if (f3 == 3'd5) begin
                    if (f7 == 7'h20) alu = ALU_SRA;
                    else if (f7 != 7'h00) ill = 1;
                end
            end
            7'b0110111: begin we = 1; o2 = 1; imm = insn & 32'hFFFFF000; alu = ALU_PASS2; end
            7'b0010111: begin we = 1; o1 = 1; o2 = 1; imm = insn & 32'hFFFFF000; end
            7'b0000011: begin
                we = 1; o2 = 1; imm = sx >>> 20; ld = ld_tab[f3]; ill = (ld == 3'd0);
            end
            7'b0100011: begin
                o2 = 1; imm = ((sx >>> 25) * 32) + int'(insn[11:7]);
                if (f3 < 3'd3) st = f3[1:0] + 2'd1; else ill = 1;
            end
            7'b1100011: begin
                imm = ((sx >>> 31) * 4096) + int'(insn[7]) * 2048 + int'(insn[30:25]) * 32
                      + int'(insn[11:8]) * 2;
                alu = br_tab[f3]; ill = (f3 == 3'd2 || f3 == 3'd3);
            end
            7'b1101111: begin
                we = 1; o1 = 1; o2 = 1; alu = ALU_JAL;
                imm = ((sx >>> 31) * 1048576) + int'(insn[19:12]) * 4096
                      + int'(insn[20]) * 2048 + int'(insn[30:21]) * 2;
            end
            7'b1100111: begin
                we = 1; o2 = 1; imm = sx >>> 20; alu = ALU_JALR; ill = (f3 != 3'd0);
            end
            default: ill = 1;
        endcase
        if (ill) begin
            alu = ALU_ADD; o1 = 0; o2 = 0; ld = 0; st = 0; md = 0; mdop = 0; we = 0;
        end
        if (insn[11:7] == 5'd0) we = 0;
        return {pc, imm, insn[11:7], insn[19:15], insn[24:20], alu, o1, o2, we, ld, st,
                md, mdop, ill};
    endfunction

    task automatic check_all();
        chk("m.in_ready", 97'(m_in_ready), 97'(q.size() < 2));
        chk("n.in_ready", 97'(n_in_ready), 97'(q.size() < 2));
        chk("m.out_valid", 97'(m_out_valid), 97'(q.size() > 0));
        chk("n.out_valid", 97'(n_out_valid), 97'(q.size() > 0));
        if (q.size() > 0) begin
            chk("m.payload", obs_m, ref_dec(q[0].insn, q[0].pc, 1'b1));
            chk("n.payload", obs_n, ref_dec(q[0].insn, q[0].pc, 1'b0));
        end
    endtask

    // One clock: drive between edges, advance the model at the edge, check at negedge.
    task automatic cyc(input logic v, input logic [31:0] insn, input logic [31:0] pc,
                       input logic ordy, input logic fl, input logic r);
        int n;
        beat_t b;
        in_valid = v; in_insn = insn; in_pc = pc; out_ready = ordy; flush = fl; rst = r;
        @(posedge clk);
        n = q.size();
        if (r || fl) begin
            q.delete();
        end else begin
            if (n > 0 && ordy) void'(q.pop_front());
            if (v && n < 2) begin
                b.insn = insn; b.pc = pc;
                q.push_back(b);
            end
        end
        @(negedge clk);
        check_all();
    endtask

    function automatic logic [31:0] gen_insn();
        logic [31:0] w;
        logic [6:0] ops [9];
        int k;
        ops = '{7'b0110011, 7'b0010011, 7'b0110111, 7'b0010111, 7'b0000011, 7'b0100011,
                7'b1100011, 7'b1101111, 7'b1100111};
        w = $urandom;
        k = $urandom_range(0, 15);
        if (k < 9) begin
            w[6:0] = ops[k];
        end else if (k < 11) begin
            w[6:0] = 7'b0110011;
            w[31:25] = (k == 9) ? 7'h01 : 7'h20;
        end else if (k == 11) begin
            w[6:0] = 7'b0010011;
            w[31:25] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
        end
        return w;
    endfunction

    initial begin
        rst = 1; flush = 0; in_valid = 0; out_ready = 0; in_insn = '0; in_pc = '0;
        cyc(0, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 1);
        chk("rst.m_payload", obs_m, 97'd0);
        chk("rst.n_payload", obs_n, 97'd0);
        cyc(0, 0, 0, 0, 0, 0);

        // addi x1,x0,5
        cyc(1, 32'h00500093, 32'h100, 1, 0, 0);
        chk("addi.valid", 97'(m_out_valid), 97'd1);
        chk("addi.imm", 97'(m_imm), 97'd5);
        chk("addi.alu", 97'(m_alu), 97'(ALU_ADD));
        chk("addi.rd", 97'(m_rd), 97'd1);
        chk("addi.we", 97'(m_we), 97'd1);
        cyc(0, 0, 0, 1, 0, 0);

        // Four beats with backpressure after the second accept.
        cyc(1, 32'h00100093, 32'h200, 1, 0, 0);
        cyc(1, 32'h00200113, 32'h204, 0, 0, 0);
        chk("bp.in_ready_low", 97'(m_in_ready), 97'd0);
        cyc(1, 32'h00300193, 32'h208, 0, 0, 0);
        chk("bp.hold_pc", 97'(m_pc), 97'h200);
        cyc(1, 32'h00300193, 32'h208, 1, 0, 0);
        chk("bp.order2", 97'(m_pc), 97'h204);
        cyc(1, 32'h00300193, 32'h208, 1, 0, 0);
        chk("bp.order3", 97'(m_pc), 97'h208);
        cyc(1, 32'h00400213, 32'h20C, 1, 0, 0);
        chk("bp.order4", 97'(m_pc), 97'h20C);
        cyc(0, 0, 0, 1, 0, 0);

        // nop then all-ones word
        cyc(1, 32'h00000013, 32'h300, 1, 0, 0);
        chk("nop.we", 97'(m_we), 97'd0);
        chk("nop.ill", 97'(m_ill), 97'd0);
        cyc(1, 32'hFFFFFFFF, 32'h304, 1, 0, 0);
        chk("ones.ill", 97'(m_ill), 97'd1);
        chk("ones.we", 97'(m_we), 97'd0);

        // mul x3,x1,x2
        cyc(1, 32'h022081B3, 32'h308, 1, 0, 0);
        chk("mul.m_is_md", 97'(m_md), 97'd1);
        chk("mul.m_md_op", 97'(m_mdop), 97'd0);
        chk("mul.m_we", 97'(m_we), 97'd1);
        chk("mul.n_ill", 97'(n_ill), 97'd1);
        chk("mul.n_we", 97'(n_we), 97'd0);
        cyc(0, 0, 0, 1, 0, 0);

        // Flush from the full state with a beat offered.
        cyc(1, 32'h00100093, 32'h400, 0, 0, 0);
        cyc(1, 32'h00200113, 32'h404, 0, 0, 0);
        cyc(1, 32'h00300193, 32'h408, 0, 1, 0);
        chk("flush.valid", 97'(m_out_valid), 97'd0);
        chk("flush.in_ready", 97'(m_in_ready), 97'd1);
        cyc(0, 0, 0, 1, 0, 0);
        chk("flush.no_ghost", 97'(n_out_valid), 97'd0);

        // beq x0,x0,-4
        cyc(1, 32'hFE000EE3, 32'h500, 1, 0, 0);
        chk("beq.imm", 97'(m_imm), 97'hFFFFFFFC);
        chk("beq.alu", 97'(m_alu), 97'(ALU_BEQ));
        chk("beq.op2", 97'(m_o2), 97'd0);
        chk("beq.we", 97'(m_we), 97'd0);
        chk("beq.store", 97'(m_st), 97'd0);

        // Reset in the middle of a stream clears payload too.
        cyc(1, 32'h00700393, 32'h600, 0, 0, 0);
        cyc(1, 32'h00800413, 32'h604, 0, 0, 1);
        chk("midrst.payload", obs_m, 97'd0);

        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(0, 3) != 0), gen_insn(), $urandom & 32'hFFFFFFFC,
                ($urandom_range(0, 2) != 0), ($urandom_range(0, 49) == 0),
                ($urandom_range(0, 499) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
